axi4_lite_master_bridge: RTL and testbench
==========================================

AXI4_LITE_MASTER_BRIDGE -- requirements
Module: axi4_lite_master_bridge

Interface
REQ-001 Parameter: TIMEOUT, 16'd1024, cycles in a bus-wait state before err_timeout asserts.
REQ-002 Parameter: PROT, 3'b000, value driven on M_AXI_AWPROT and M_AXI_ARPROT.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 aclk  in  1  sole clock, rising edge.
REQ-005 areset  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  command request; cmd_ready  out  1  command accept.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  32  byte address; cmd_wdata  in  32  write data; cmd_wstrb  in  4  byte strobes.
REQ-009 rsp_valid  out  1  response valid; rsp_ready  in  1  response accept.
REQ-010 rsp_rdata  out  32  read data (0 for writes); rsp_resp  out  2  BRESP/RRESP copy; rsp_write  out  1  echoes command type.
REQ-011 M_AXI_AWADDR/AWPROT/AWVALID out 32/3/1, M_AXI_AWREADY in 1: write address channel.
REQ-012 M_AXI_WDATA/WSTRB/WVALID out 32/4/1, M_AXI_WREADY in 1: write data channel.
REQ-013 M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1: write response channel.
REQ-014 M_AXI_ARADDR/ARPROT/ARVALID out 32/3/1, M_AXI_ARREADY in 1: read address channel.
REQ-015 M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1: read data channel.
REQ-016 err_timeout  out  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP; one transaction outstanding at a time.
REQ-018 cmd_ready SHALL be 1 only in IDLE; handshake = cmd_valid & cmd_ready; command fields registered at handshake.
REQ-019 IDLE -> WADDR_DATA on accepted write; IDLE -> RADDR on accepted read; AWVALID+WVALID (or ARVALID) SHALL assert the cycle after acceptance.
REQ-020 WADDR_DATA: AWVALID held until AWREADY sampled high, WVALID held until WREADY sampled high, independently; AW/W payload stable while valid.
REQ-021 WADDR_DATA -> WRESP once both AW and W handshakes completed (same or different cycles); BREADY=1 only in WRESP.
REQ-022 WRESP -> RSP on BVALID&BREADY; BRESP captured into rsp_resp, rsp_rdata=0, rsp_write=1.
REQ-023 RADDR: ARVALID held until ARREADY; then RDATA with RREADY=1; RDATA -> RSP on RVALID&RREADY capturing RDATA/RRESP, rsp_write=0.
REQ-024 RSP: rsp_valid=1, outputs stable until rsp_ready; RSP -> IDLE on rsp_valid&rsp_ready; new command accepted no earlier than following cycle.
REQ-025 Minimum latency with always-ready slave: write cmd accept cycle 0, AW/W cycle 1, B cycle 2 earliest, rsp_valid cycle 3.
REQ-026 VALID signals SHALL never depend combinationally on READY inputs; once asserted, VALID SHALL NOT drop before its handshake.
REQ-027 Timeout counter (16-bit, saturating) SHALL clear on command accept and increment each cycle in WADDR_DATA/WRESP/RADDR/RDATA.
REQ-028 err_timeout SHALL set when counter reaches TIMEOUT, stay set, clear only on next command accept or reset; FSM keeps waiting (no abort, protocol preserved).
REQ-029 Non-OKAY responses (SLVERR/DECERR) SHALL be passed through unchanged, not retried.

Reset
REQ-030 On areset: FSM=IDLE, all VALID/READY outputs 0 except cmd_ready=1, rsp_* =0, M_AXI_* addr/data/strb=0, PROT=PROT, counter=0, err_timeout=0.
REQ-031 Reset mid-transaction SHALL drop every VALID immediately (async) and discard the transaction; no response issued.

Verification
REQ-032 Write 0x10<-0xDEADBEEF, strb 0xF, slave always ready, BRESP=00 -> AW/W cycle 1, rsp_valid cycle 3, rsp_resp=00, rsp_write=1.
REQ-033 Write with WREADY delayed 5 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held, BREADY only after W done.
REQ-034 Read 0x20, ARREADY delayed 3, RDATA=0x12345678 RRESP=10 -> rsp_rdata=0x12345678, rsp_resp=10, rsp_write=0.
REQ-035 rsp_ready low 4 cycles in RSP -> rsp_* stable, cmd_ready=0 throughout; back-to-back cmd accepted cycle after rsp handshake.
REQ-036 TIMEOUT=8, slave never asserts BVALID -> err_timeout=1 after 8 wait cycles, BREADY still 1; BVALID later completes normally.
REQ-037 areset pulse while ARVALID=1 -> ARVALID=0 same cycle, cmd_ready=1, err_timeout=0, no rsp_valid.

Source files
------------

// File: rtl/axi4_lite_master_bridge.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_bridge
//
// Turns a simple valid/ready command interface into single AXI4-Lite
// transactions, one at a time, and returns the slave's answer on a
// valid/ready response interface. A saturating wait counter raises a sticky
// err_timeout flag when the slave takes too long. The bridge keeps waiting
// after a timeout, so the AXI protocol is never broken.
//
// Ports
//   aclk, areset            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     : command handshake (ready only when idle)
//   cmd_write/addr/wdata/wstrb : command payload, captured at handshake
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata/resp/write    : read data (0 on writes), BRESP/RRESP, type echo
//   M_AXI_AW*/W*/B*/AR*/R*  : AXI4-Lite master channels
//   err_timeout             : sticky timeout flag, cleared on next command
// ---------------------------------------------------------------------------
module axi4_lite_master_bridge #(
  parameter logic [15:0] TIMEOUT = 16'd1024,
  parameter logic [2:0]  PROT    = 3'b000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_write,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        write_q, write_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic aw_hs, w_hs, waiting;

  // All VALID/READY outputs are decoded from registered state only, so no
  // VALID can ever depend combinationally on a READY input.
  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RSP);
  assign M_AXI_AWVALID = (state_q == WADDR_DATA) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == WADDR_DATA) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == WRESP);
  assign M_AXI_ARVALID = (state_q == RADDR);
  assign M_AXI_RREADY  = (state_q == RDATA);

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_AWPROT  = PROT;
  assign M_AXI_ARPROT  = PROT;

  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_write     = write_q;
  assign err_timeout   = err_q;

  assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  assign waiting = (state_q == WADDR_DATA) || (state_q == WRESP) ||
                   (state_q == RADDR) || (state_q == RDATA);

  // Next-state logic. AW and W complete independently; the done flags
  // remember which half has already handshaked so its VALID drops.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = 16'd0;
          err_d     = 1'b0;
          state_d   = cmd_write ? WADDR_DATA : RADDR;
        end
      end
      WADDR_DATA: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
      end
      WRESP: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = 32'd0;
          state_d = RSP;
        end
      end
      RADDR: begin
        if (M_AXI_ARREADY) state_d = RDATA;
      end
      RDATA: begin
        if (M_AXI_RVALID) begin
          resp_d  = M_AXI_RRESP;
          rdata_d = M_AXI_RDATA;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Saturating wait counter; the flag is raised on the same edge the
    // counter reaches the limit.
    if (waiting) begin
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      if (cnt_d >= TIMEOUT) err_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= 32'd0;
      resp_q    <= 2'd0;
      cnt_q     <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_master_bridge
//
// Scoreboard bench: every command pushes its expected response and a slave
// plan into queues. A slave process plays the AXI slave from the plan and
// checks the channel payloads and handshake rules; a monitor process pops
// and compares responses and models the timeout flag from wait cycles.
// ---------------------------------------------------------------------------
module tb_axi4_lite_master_bridge;

  localparam logic [15:0] TO = 16'd8;
  localparam logic [2:0]  PR = 3'b101;

  logic        aclk, areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY, err_timeout;

  axi4_lite_master_bridge #(.TIMEOUT(TO), .PROT(PR)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .err_timeout(err_timeout)
  );

  // lag >= 0 forces the second-phase ready (W for writes, AR for reads)
  // low for that many cycles; rdelay delays BVALID/RVALID.
  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lag;
    int          rdelay;
  } plan_t;

  typedef struct {
    bit          write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  plan_t planQ[$];
  exp_t  expQ[$];
  int    nChecks = 0;
  int    nFails  = 0;
  bit    randReady = 0;
  bit    rspRandom = 0;
  int    holdRsp = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command and queue its plan and expected response.
  task automatic applyStimulus(input bit wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] r, input logic [31:0] rd,
                               input int lag, input int rdelay);
    plan_t p;
    exp_t  e;
    bit    accepted = 0;
    p.write = wr; p.addr = a; p.wdata = d; p.wstrb = s; p.resp = r;
    p.rdata = rd; p.lag = lag; p.rdelay = rdelay;
    e.write = wr; e.rdata = wr ? 32'd0 : rd; e.resp = r;
    planQ.push_back(p);
    expQ.push_back(e);
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      if (cmd_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      $display("[TB] FAIL cmd_accept: command at 0x%0h never accepted", a);
      $fatal(1, "[TB] command stuck");
    end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge aclk);
      if (expQ.size() == 0 && planQ.size() == 0) begin
        done = 1;
        break;
      end
    end
    nChecks++;
    if (!done) begin
      nFails++;
      $display("[TB] FAIL wait_idle: %0d responses outstanding, required 0",
               expQ.size());
    end
  endtask

  // Response ready: optionally held low for a number of RSP cycles.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      if (holdRsp > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) holdRsp--;
      end else begin
        rsp_ready = rspRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
  end

  // Slave model state
  bit    sAwSeen, sWSeen, sArSeen, sAwPend, sWPend, sArPend, sBHs, sRHs;
  int    sAwAge, sArAge, sBWait, sRWait;
  plan_t cur;

  task automatic slaveClear();
    sAwSeen = 0; sWSeen = 0; sArSeen = 0;
    sAwPend = 0; sWPend = 0; sArPend = 0;
    sBHs = 0; sRHs = 0;
    sAwAge = 0; sArAge = 0; sBWait = 0; sRWait = 0;
  endtask

  // Slave: sample handshakes at the falling edge, drive after the rising one.
  initial begin
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0;
    M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    slaveClear();
    forever begin
      @(negedge aclk);
      if (areset) begin
        slaveClear();
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      end else begin
        if (planQ.size() > 0) cur = planQ[0];
        else begin
          cur.write = 0; cur.addr = 0; cur.wdata = 0; cur.wstrb = 0;
          cur.resp = 0; cur.rdata = 0; cur.lag = -1; cur.rdelay = 0;
        end
        if (sAwPend) checkOutput("awvalid_held", M_AXI_AWVALID, 1);
        if (sWPend)  checkOutput("wvalid_held", M_AXI_WVALID, 1);
        if (sArPend) checkOutput("arvalid_held", M_AXI_ARVALID, 1);
        if (sAwSeen) checkOutput("awvalid_after_hs", M_AXI_AWVALID, 0);
        if (sWSeen)  checkOutput("wvalid_after_hs", M_AXI_WVALID, 0);
        if (M_AXI_BREADY)
          checkOutput("bready_after_aw_w", {63'd0, sAwSeen && sWSeen}, 1);
        sBHs = M_AXI_BVALID && M_AXI_BREADY;
        sRHs = M_AXI_RVALID && M_AXI_RREADY;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          checkOutput("awaddr", M_AXI_AWADDR, cur.addr);
          checkOutput("awprot", M_AXI_AWPROT, PR);
          sAwSeen = 1;
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          checkOutput("wdata", M_AXI_WDATA, cur.wdata);
          checkOutput("wstrb", M_AXI_WSTRB, cur.wstrb);
          sWSeen = 1;
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          checkOutput("araddr", M_AXI_ARADDR, cur.addr);
          checkOutput("arprot", M_AXI_ARPROT, PR);
          sArSeen = 1;
        end
        if (sAwSeen) sAwAge++;
        if (M_AXI_ARVALID) sArAge++;
        sAwPend = M_AXI_AWVALID && !M_AXI_AWREADY;
        sWPend  = M_AXI_WVALID && !M_AXI_WREADY;
        sArPend = M_AXI_ARVALID && !M_AXI_ARREADY;
      end
      @(posedge aclk); #1;
      if (!areset) begin
        M_AXI_AWREADY = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (cur.write && cur.lag >= 0)
          M_AXI_WREADY = sAwSeen && (sAwAge >= cur.lag);
        else
          M_AXI_WREADY = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (!cur.write && cur.lag >= 0)
          M_AXI_ARREADY = (sArAge >= cur.lag);
        else
          M_AXI_ARREADY = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (sBHs) begin
          M_AXI_BVALID = 0;
          M_AXI_BRESP  = 2'($urandom);
          if (planQ.size() > 0) void'(planQ.pop_front());
          sAwSeen = 0; sWSeen = 0; sAwAge = 0; sBWait = 0; sBHs = 0;
        end else if (sAwSeen && sWSeen && !M_AXI_BVALID) begin
          if (sBWait >= cur.rdelay) begin
            M_AXI_BVALID = 1; M_AXI_BRESP = cur.resp;
          end else sBWait++;
        end
        if (sRHs) begin
          M_AXI_RVALID = 0;
          if (planQ.size() > 0) void'(planQ.pop_front());
          sArSeen = 0; sArAge = 0; sRWait = 0; sRHs = 0;
        end else if (sArSeen && !M_AXI_RVALID) begin
          if (sRWait >= cur.rdelay) begin
            M_AXI_RVALID = 1; M_AXI_RRESP = cur.resp; M_AXI_RDATA = cur.rdata;
          end else sRWait++;
        end
        if (!M_AXI_RVALID) begin
          M_AXI_RDATA = $urandom;
          M_AXI_RRESP = 2'($urandom);
        end
      end
    end
  end

  // Monitor: response scoreboard plus the timeout flag model, where every
  // cycle between command accept and the first response cycle is a wait.
  bit mBusy, mExpErr, mPrevRspHs, mRspHs;
  int mWaits;
  initial begin
    mBusy = 0; mExpErr = 0; mPrevRspHs = 0; mWaits = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        mBusy = 0; mExpErr = 0; mPrevRspHs = 0; mWaits = 0;
      end else begin
        checkOutput("err_timeout", err_timeout, mExpErr);
        if (mPrevRspHs) checkOutput("cmd_ready_after_rsp", cmd_ready, 1);
        if (rsp_valid) begin
          checkOutput("cmd_ready_in_rsp", cmd_ready, 0);
          if (expQ.size() == 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL rsp_unexpected: rsp_valid=1, required 0");
          end else begin
            checkOutput("rsp_rdata", rsp_rdata, expQ[0].rdata);
            checkOutput("rsp_resp", rsp_resp, expQ[0].resp);
            checkOutput("rsp_write", rsp_write, expQ[0].write);
          end
        end
        mRspHs = rsp_valid && rsp_ready;
        if (mRspHs && expQ.size() > 0) void'(expQ.pop_front());
        if (cmd_valid && cmd_ready) begin
          mBusy = 1; mWaits = 0; mExpErr = 0;
        end else if (mBusy && !rsp_valid) begin
          mWaits++;
          if (mWaits >= int'(TO)) mExpErr = 1;
        end else if (rsp_valid) mBusy = 0;
        mPrevRspHs = mRspHs;
      end
    end
  end

  initial begin
    bit seen;
    areset = 1'b1; cmd_valid = 0; cmd_write = 0;
    cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    @(negedge aclk);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                               rsp_valid}, 0);
    checkOutput("rst_readies", {M_AXI_BREADY, M_AXI_RREADY}, 0);
    checkOutput("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 0);
    checkOutput("rst_payload", {M_AXI_AWADDR, M_AXI_WSTRB}, 0);
    checkOutput("rst_wdata_araddr", {M_AXI_WDATA, M_AXI_ARADDR}, 0);
    checkOutput("rst_prot", {M_AXI_AWPROT, M_AXI_ARPROT}, {PR, PR});
    checkOutput("rst_err", err_timeout, 0);
    @(posedge aclk); #2;
    areset = 1'b0;

    // Minimum-latency write with an always-ready slave.
    applyStimulus(1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 32'd0, -1, 0);
    @(negedge aclk);
    checkOutput("lat_aw_w_cycle1", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    @(negedge aclk);
    checkOutput("lat_bready_cycle2", M_AXI_BREADY, 1);
    @(negedge aclk);
    checkOutput("lat_rsp_cycle3", rsp_valid, 1);
    waitIdle();

    // W ready held off after AW completes.
    applyStimulus(1, 32'h44, 32'hA5A55A5A, 4'h3, 2'b00, 32'd0, 5, 0);
    waitIdle();

    // Slow read address, SLVERR passed through.
    applyStimulus(0, 32'h20, 32'd0, 4'h0, 2'b10, 32'h12345678, 3, 1);
    waitIdle();

    // Response back-pressure, then a back-to-back command.
    holdRsp = 4;
    applyStimulus(0, 32'h24, 32'd0, 4'h0, 2'b00, 32'hCAFEF00D, -1, 0);
    applyStimulus(1, 32'h28, 32'h0BADF00D, 4'hC, 2'b01, 32'd0, -1, 0);
    waitIdle();

    // Slave delays BVALID well beyond the timeout; DECERR passed through.
    applyStimulus(1, 32'h30, 32'h11223344, 4'hF, 2'b11, 32'd0, -1, 12);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (err_timeout) begin
        seen = 1;
        break;
      end
    end
    checkOutput("timeout_seen", {63'd0, seen}, 1);
    checkOutput("bready_during_timeout", M_AXI_BREADY, 1);
    waitIdle();

    // Randomized traffic.
    randReady = 1; rspRandom = 1;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
                    $urandom, 4'($urandom), 2'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                    int'($urandom_range(0, 4)));
    end
    waitIdle();

    // Reset while ARVALID is pending and the flag is set.
    randReady = 0; rspRandom = 0;
    applyStimulus(0, 32'h50, 32'd0, 4'h0, 2'b00, 32'h55AA55AA, 999, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (M_AXI_ARVALID) begin
        seen = 1;
        break;
      end
    end
    repeat (10) @(negedge aclk);
    checkOutput("arvalid_before_reset", {63'd0, seen && M_AXI_ARVALID}, 1);
    checkOutput("err_before_reset", err_timeout, 1);
    #2;
    areset = 1'b1;
    planQ.delete();
    expQ.delete();
    #1;
    checkOutput("reset_arvalid", M_AXI_ARVALID, 0);
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_err", err_timeout, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    @(negedge aclk);
    @(posedge aclk); #2;
    areset = 1'b0;

    // Recovery after reset.
    applyStimulus(0, 32'h60, 32'd0, 4'h0, 2'b00, 32'h87654321, -1, 0);
    waitIdle();
    repeat (3) @(negedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
